// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers (toggle or pulse output); new config is staged and loaded at restart points.
// Outputs are registered and change only on the evaluating edge; no backpressure, writes are always accepted.
module clk_div_bank #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 32,
  parameter int DIV_INIT  = 1000000,
  parameter int MODE_INIT = 0,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic [N_CH-1:0]  sclk,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  upd_pend
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_INIT);
  localparam logic             MODE_RST = (MODE_INIT != 0);

  logic [CNT_W-1:0] cnt_q      [N_CH];
  logic [CNT_W-1:0] cnt_d      [N_CH];
  logic [CNT_W-1:0] act_div_q  [N_CH];
  logic [CNT_W-1:0] act_div_d  [N_CH];
  logic [CNT_W-1:0] pend_div_q [N_CH];
  logic [CNT_W-1:0] pend_div_d [N_CH];

  logic [N_CH-1:0] act_mode_q, act_mode_d;
  logic [N_CH-1:0] pend_mode_q, pend_mode_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] sclk_d, tick_d;
  logic [N_CH-1:0] hit, term, restart;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hit[i]     = wr_en && (wr_ch == CH_W'(i));
      term[i]    = en[i] && (cnt_q[i] == act_div_q[i]);
      restart[i] = sync || !en[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]       = cnt_q[i];
      act_div_d[i]   = act_div_q[i];
      pend_div_d[i]  = pend_div_q[i];
      act_mode_d[i]  = act_mode_q[i];
      pend_mode_d[i] = pend_mode_q[i];
      pend_d[i]      = pend_q[i];
      sclk_d[i]      = sclk[i];
      tick_d[i]      = 1'b0;

      // Restart points load config; a write landing on one bypasses staging.
      if (restart[i] || term[i]) begin
        pend_d[i] = 1'b0;
        if (hit[i]) begin
          act_div_d[i]   = wr_div;
          act_mode_d[i]  = wr_mode;
          pend_div_d[i]  = wr_div;
          pend_mode_d[i] = wr_mode;
        end else if (pend_q[i]) begin
          act_div_d[i]  = pend_div_q[i];
          act_mode_d[i] = pend_mode_q[i];
        end
      end else if (hit[i]) begin
        pend_div_d[i]  = wr_div;
        pend_mode_d[i] = wr_mode;
        pend_d[i]      = 1'b1;
      end

      if (restart[i]) begin
        cnt_d[i]  = '0;
        sclk_d[i] = 1'b0;
      end else if (term[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        // The mode being loaded on this edge already governs sclk.
        sclk_d[i] = (hit[i] ? wr_mode : (pend_q[i] ? pend_mode_q[i] : act_mode_q[i]))
                    ? 1'b1 : ~sclk[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (act_mode_q[i]) sclk_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]      <= '0;
        act_div_q[i]  <= DIV_RST;
        pend_div_q[i] <= DIV_RST;
      end
      act_mode_q  <= {N_CH{MODE_RST}};
      pend_mode_q <= {N_CH{MODE_RST}};
      pend_q      <= '0;
      sclk        <= '0;
      tick        <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        act_div_q[i]  <= act_div_d[i];
        pend_div_q[i] <= pend_div_d[i];
      end
      act_mode_q  <= act_mode_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      sclk        <= sclk_d;
      tick        <= tick_d;
    end
  end

  assign upd_pend = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed and random stimulus for clk_div_bank against a countdown-based reference model.
module tb_clk_div_bank;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int DI = 3;
  localparam int MI = 0;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] en = '0;
  logic         sync = 1'b0;
  logic         wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [W-1:0] wr_div = '0;
  logic         wr_mode = 1'b0;
  logic [N-1:0] sclk, tick, upd_pend;

  int errors = 0;
  int checks = 0;

  // Reference: cycles remaining until the next terminal edge, plus staged config.
  int m_left [N];
  int m_div  [N];
  int m_pdiv [N];
  bit m_mode [N];
  bit m_pmode[N];
  bit m_pend [N];
  bit m_sclk [N];
  bit m_tick [N];

  always #5 clk = ~clk;

  clk_div_bank #(
    .N_CH(N), .CNT_W(W), .DIV_INIT(DI), .MODE_INIT(MI), .CH_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
    .sclk(sclk), .tick(tick), .upd_pend(upd_pend)
  );

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_left[c] = DI; m_div[c] = DI; m_pdiv[c] = DI;
      m_mode[c] = (MI != 0); m_pmode[c] = (MI != 0);
      m_pend[c] = 0; m_sclk[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit h;
      h = wr_en && (int'(wr_ch) == c);
      if (sync || !en[c] || m_left[c] == 0) begin
        if (h) begin
          m_div[c] = int'(wr_div); m_mode[c] = wr_mode;
          m_pdiv[c] = int'(wr_div); m_pmode[c] = wr_mode;
        end else if (m_pend[c]) begin
          m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c];
        end
        m_pend[c] = 0;
        m_left[c] = m_div[c];
        if (sync || !en[c]) begin
          m_sclk[c] = 0; m_tick[c] = 0;
        end else begin
          m_tick[c] = 1;
          m_sclk[c] = m_mode[c] ? 1'b1 : !m_sclk[c];
        end
      end else begin
        if (h) begin
          m_pdiv[c] = int'(wr_div); m_pmode[c] = wr_mode; m_pend[c] = 1;
        end
        m_left[c] = m_left[c] - 1;
        m_tick[c] = 0;
        if (m_mode[c]) m_sclk[c] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [N-1:0] es, et, ep;
    for (int c = 0; c < N; c++) begin
      es[c] = m_sclk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    chk({tag, ".sclk"}, 32'(sclk), 32'(es));
    chk({tag, ".tick"}, 32'(tick), 32'(et));
    chk({tag, ".upd_pend"}, 32'(upd_pend), 32'(ep));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0;
    #1;
    model_reset();
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write(input int ch, input int d, input bit m);
    wr_en = 1'b1; wr_ch = CW'(ch); wr_div = W'(d); wr_mode = m;
  endtask

  initial begin
    // Reset period: ticks every DIV_INIT+1 edges, sclk toggles on each.
    do_reset();
    en = 5'b00001;
    for (int e = 1; e <= 12; e++) begin
      cycle("t1");
      chk("t1.tick0", 32'(tick[0]), 32'(e % 4 == 0));
      chk("t1.sclk0", 32'(sclk[0]), 32'((e >= 4 && e < 8) || e >= 12));
    end

    // Divisor change mid-period completes the old period first.
    do_reset();
    write(1, 9, 0);
    cycle("t2.cfg");
    wr_en = 1'b0;
    en = 5'b00010;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) write(1, 4, 0);
      else wr_en = 1'b0;
      cycle("t2");
      chk("t2.tick1", 32'(tick[1]), 32'(e == 10 || e == 15 || e == 20));
      chk("t2.pend1", 32'(upd_pend[1]), 32'(e >= 5 && e < 10));
    end
    wr_en = 1'b0;

    // Divisor zero: tick every edge; toggle gives clk/2, pulse holds high.
    do_reset();
    write(2, 0, 0);
    cycle("t3.cfg");
    wr_en = 1'b0;
    en = 5'b00100;
    for (int e = 1; e <= 6; e++) begin
      cycle("t3.tog");
      chk("t3.tick2", 32'(tick[2]), 32'd1);
      chk("t3.sclk2", 32'(sclk[2]), 32'(e % 2));
    end
    write(2, 0, 1);
    for (int e = 1; e <= 5; e++) begin
      cycle("t3.pul");
      wr_en = 1'b0;
      chk("t3.sclk2p", 32'(sclk[2]), 32'd1);
    end

    // Sync realigns two channels started out of phase.
    do_reset();
    en = 5'b00001;
    cycle("t4"); cycle("t4");
    en = 5'b01001;
    for (int e = 0; e < 5; e++) cycle("t4");
    sync = 1'b1;
    cycle("t4.sync");
    sync = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle("t4");
      chk("t4.tick0", 32'(tick[0]), 32'(k % 4 == 0));
      chk("t4.tick3", 32'(tick[3]), 32'(k % 4 == 0));
    end

    // Write on the terminal edge bypasses staging; out-of-range channel ignored.
    do_reset();
    en = 5'b00001;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) write(0, 7, 0);
      else wr_en = 1'b0;
      cycle("t5");
      chk("t5.tick0", 32'(tick[0]), 32'(e == 4 || e == 12));
      chk("t5.pend0", 32'(upd_pend[0]), 32'd0);
    end
    en = 5'b11111;
    write(5, 1, 1);
    cycle("t5.oor");
    chk("t5.oor_pend", 32'(upd_pend), 32'd0);
    write(7, 0, 1);
    cycle("t5.oor7");
    wr_en = 1'b0;
    for (int e = 0; e < 16; e++) cycle("t5.run");

    // Asynchronous reset mid-period drops outputs and discards pending writes.
    do_reset();
    en = 5'b11111;
    for (int e = 1; e <= 4; e++) cycle("t6");
    write(1, 6, 0);
    cycle("t6.wr");
    wr_en = 1'b0;
    chk("t6.pre_pend1", 32'(upd_pend[1]), 32'd1);
    chk("t6.pre_sclk", 32'(sclk), 32'h1f);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6.rst_sclk", 32'(sclk), 32'd0);
    chk("t6.rst_tick", 32'(tick), 32'd0);
    chk("t6.rst_pend", 32'(upd_pend), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle("t6.post");
      chk("t6.tick1", 32'(tick[1]), 32'(e % 4 == 0));
    end

    // Random traffic against the reference model.
    do_reset();
    for (int e = 0; e < 400; e++) begin
      for (int c = 0; c < N; c++) en[c] = ($urandom % 8) != 0;
      sync    = ($urandom % 40) == 0;
      wr_en   = ($urandom % 4) == 0;
      wr_ch   = CW'($urandom % 8);
      wr_div  = W'($urandom % 11);
      wr_mode = 1'($urandom % 2);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
